// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_transmitter among N_REQ byte producers.
// Sequences grant -> single-cycle Tx_WR -> wait for Tx_BUSY to rise and fall, and owns baud/enable config.
module uart_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TO_CYC = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  input  logic                 en,
  input  logic [2:0]           cfg_baud,
  input  logic                 cfg_wr,
  output logic [7:0]           Tx_DATA,
  output logic                 Tx_WR,
  output logic                 Tx_EN,
  output logic [2:0]           baud_select,
  input  logic                 Tx_BUSY,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int CNT_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t           state;
  logic [2:0]       rr_ptr;
  logic [CNT_W-1:0] to_cnt;
  logic             cfg_pend;
  logic [2:0]       cfg_val;

  logic [7:0]       req_ext;
  logic [63:0]      data_ext;
  logic             found;
  logic [2:0]       pick_id;
  logic [3:0]       cand;
  logic [7:0]       pick_oh;
  logic [2:0]       next_ptr;

  // Search upward from rr_ptr, wrapping modulo N_REQ; first set request wins.
  always_comb begin
    req_ext  = 8'(req);
    data_ext = 64'(req_data);
    found    = 1'b0;
    pick_id  = 3'd0;
    cand     = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(N_REQ))
        cand = cand - 4'(N_REQ);
      if (!found && req_ext[cand[2:0]]) begin
        found   = 1'b1;
        pick_id = cand[2:0];
      end
    end
    pick_oh  = 8'b1 << pick_id;
    next_ptr = (pick_id == 3'(N_REQ - 1)) ? 3'd0 : pick_id + 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= 3'd0;
      to_cnt      <= '0;
      cfg_pend    <= 1'b0;
      cfg_val     <= 3'd0;
      Tx_DATA     <= 8'd0;
      Tx_WR       <= 1'b0;
      ack         <= '0;
      Tx_EN       <= 1'b0;
      baud_select <= 3'b111;
      grant_id    <= 3'd0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      Tx_EN <= en;
      Tx_WR <= 1'b0;
      ack   <= '0;
      if (cfg_wr)
        err_timeout <= 1'b0;
      // A config write outside IDLE is parked until the next IDLE edge; later strobes overwrite it.
      if (cfg_wr && state != S_IDLE) begin
        cfg_pend <= 1'b1;
        cfg_val  <= cfg_baud;
      end

      case (state)
        S_IDLE: begin
          if (cfg_pend) begin
            // Applying parked config consumes this edge, so the grant waits one cycle.
            baud_select <= cfg_wr ? cfg_baud : cfg_val;
            cfg_pend    <= 1'b0;
          end else if (en && found) begin
            Tx_DATA  <= data_ext[{pick_id, 3'b000} +: 8];
            grant_id <= pick_id;
            rr_ptr   <= next_ptr;
            Tx_WR    <= 1'b1;
            ack      <= pick_oh[N_REQ-1:0];
            busy     <= 1'b1;
            state    <= S_WRITE;
            if (cfg_wr) begin
              cfg_pend <= 1'b1;
              cfg_val  <= cfg_baud;
            end
          end else if (cfg_wr) begin
            baud_select <= cfg_baud;
          end
        end

        S_WRITE: begin
          to_cnt <= '0;
          state  <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (Tx_BUSY) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt == CNT_W'(TO_CYC - 1)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (!Tx_BUSY) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a hand-driven Tx_BUSY stands in for the transmitter.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_uart_tx_arbiter;

  localparam int N_REQ  = 4;
  localparam int TO_CYC = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               en;
  logic [2:0]         cfg_baud;
  logic               cfg_wr;
  logic [7:0]         Tx_DATA;
  logic               Tx_WR;
  logic               Tx_EN;
  logic [2:0]         baud_select;
  logic               Tx_BUSY;
  logic [2:0]         grant_id;
  logic               busy;
  logic               err_timeout;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int wr_mark;

  uart_tx_arbiter #(.N_REQ(N_REQ), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .en(en), .cfg_baud(cfg_baud), .cfg_wr(cfg_wr), .Tx_DATA(Tx_DATA),
    .Tx_WR(Tx_WR), .Tx_EN(Tx_EN), .baud_select(baud_select), .Tx_BUSY(Tx_BUSY),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (Tx_WR === 1'b1) wr_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req      = '0;
    en       = 1'b0;
    cfg_wr   = 1'b0;
    cfg_baud = 3'd0;
    Tx_BUSY  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One full transfer starting from IDLE with the request already presented.
  task automatic xfer(input logic [2:0] exp_id, input logic [7:0] exp_data,
                      input logic [N_REQ-1:0] req_after);
    tick();
    chk("wr_pulse", Tx_WR, 1);
    chk("grant_id", grant_id, exp_id);
    chk("ack", ack, 4'b0001 << exp_id);
    chk("tx_data", Tx_DATA, exp_data);
    req = req_after;
    tick();
    chk("wr_drop", Tx_WR, 0);
    chk("ack_drop", ack, 0);
    Tx_BUSY = 1'b1;
    tick();
    tick();
    chk("busy_mid", busy, 1);
    Tx_BUSY = 1'b0;
    tick();
    chk("busy_end", busy, 0);
  endtask

  initial begin
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};

    // Reset values
    do_reset();
    reset = 1'b0;
    #2;
    chk("rst_wr", Tx_WR, 0);
    chk("rst_ack", ack, 0);
    chk("rst_txen", Tx_EN, 0);
    chk("rst_baud", baud_select, 3'b111);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_data", Tx_DATA, 0);

    // Single request
    do_reset();
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'h99};
    en  = 1'b1;
    req = 4'b0001;
    wr_mark = wr_cnt;
    xfer(3'd0, 8'h99, 4'b0000);
    chk("txen", Tx_EN, 1);
    tick();
    tick();
    chk("single_wr_count", wr_cnt - wr_mark, 1);

    // Simultaneous requests, round-robin order
    do_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    en  = 1'b1;
    req = 4'b1111;
    xfer(3'd0, 8'hA0, 4'b1111);
    xfer(3'd1, 8'hA1, 4'b1111);
    xfer(3'd2, 8'hA2, 4'b1111);
    xfer(3'd3, 8'hA3, 4'b1111);
    xfer(3'd0, 8'hA0, 4'b0000);

    // Pointer wrap: after grant 2, search 3 -> 0
    do_reset();
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    en  = 1'b1;
    req = 4'b0100;
    xfer(3'd2, 8'hD2, 4'b0101);
    xfer(3'd0, 8'hD0, 4'b0000);
    do_reset();
    en  = 1'b1;
    req = 4'b0100;
    xfer(3'd2, 8'hD2, 4'b1101);
    xfer(3'd3, 8'hD3, 4'b0000);

    // Timeout with Tx_BUSY held low
    do_reset();
    en  = 1'b1;
    req = 4'b0001;
    tick();
    chk("to_wr", Tx_WR, 1);
    req = 4'b0000;
    tick();
    for (int i = 0; i < TO_CYC - 1; i++) tick();
    chk("to_early", err_timeout, 0);
    chk("to_busy_early", busy, 1);
    tick();
    chk("to_set", err_timeout, 1);
    chk("to_idle", busy, 0);
    cfg_baud = 3'b011;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("to_clear", err_timeout, 0);
    chk("idle_baud", baud_select, 3'b011);

    // Deferred baud: parked during WAIT_DONE, last write wins, grant one cycle after apply
    do_reset();
    en  = 1'b1;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    Tx_BUSY = 1'b1;
    tick();
    req      = 4'b0010;
    cfg_baud = 3'b101;
    cfg_wr   = 1'b1;
    tick();
    cfg_baud = 3'b010;
    tick();
    cfg_wr = 1'b0;
    chk("dfr_hold", baud_select, 3'b111);
    Tx_BUSY = 1'b0;
    tick();
    chk("dfr_idle_baud", baud_select, 3'b111);
    chk("dfr_idle_wr", Tx_WR, 0);
    tick();
    chk("dfr_apply", baud_select, 3'b010);
    chk("dfr_no_wr", Tx_WR, 0);
    tick();
    chk("dfr_wr", Tx_WR, 1);
    chk("dfr_gid", grant_id, 1);
    chk("dfr_ack", ack, 4'b0010);
    chk("dfr_data", Tx_DATA, 8'hD1);
    req = 4'b0000;

    // Reset mid-frame, then enable gating
    do_reset();
    cfg_baud = 3'b001;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("mr_baud", baud_select, 3'b001);
    en  = 1'b1;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    Tx_BUSY = 1'b1;
    tick();
    tick();
    chk("mr_busy_pre", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_wr", Tx_WR, 0);
    chk("mr_baud_rst", baud_select, 3'b111);
    chk("mr_txen", Tx_EN, 0);
    en      = 1'b0;
    req     = 4'b1111;
    Tx_BUSY = 1'b0;
    #3;
    reset = 1'b1;
    wr_mark = wr_cnt;
    for (int i = 0; i < 50; i++) tick();
    chk("gate_no_wr", wr_cnt - wr_mark, 0);
    chk("gate_busy", busy, 0);
    en = 1'b1;
    tick();
    chk("gate_wr", Tx_WR, 1);
    chk("gate_gid", grant_id, 0);
    chk("gate_ack", ack, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_transmitter` among `N_REQ` byte producers. It picks a requester, latches its byte, issues a single-cycle `Tx_WR`, then tracks `Tx_BUSY` until the frame completes. It also owns the transmitter's `baud_select` and `Tx_EN` configuration. It sits between the client logic and the `uart_transmitter` instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TO_CYC`, default 15: maximum cycles to wait for `Tx_BUSY` to rise after `Tx_WR`.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in N_REQ: level request per requester; bit i uses byte i.
- `req_data` in 8*N_REQ: byte i is `req_data[8i+7:8i]`.
- `ack` out N_REQ: one-cycle pulse on bit i when byte i is accepted; the requester then drops or updates `req`.
- `en` in 1: arbitration enable; drives `Tx_EN`.
- `cfg_baud` in 3: new baud code.
- `cfg_wr` in 1: one-cycle strobe that writes `cfg_baud`.
- `Tx_DATA` out 8: byte to the transmitter.
- `Tx_WR` out 1: write strobe to the transmitter.
- `Tx_EN` out 1: registered copy of `en`.
- `baud_select` out 3: active baud code.
- `Tx_BUSY` in 1: transmitter busy flag.
- `grant_id` out 3: index of the current or last granted requester.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky flag; set on timeout, cleared by the next `cfg_wr`.

## Operation
- States: IDLE, WRITE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `en`=1 and `req`≠0, grant the first set bit found by searching from `rr_ptr` upward, wrapping modulo N_REQ.
  - On grant: latch the byte into `Tx_DATA`, set `grant_id`, set `rr_ptr` to (grant+1) mod N_REQ, and go to WRITE.
  - With `en`=0 no grant is made, and `req` is ignored.
- **WRITE** (exactly 1 cycle): `Tx_WR`=1 and `ack[grant_id]`=1. Go to WAIT_BUSY.
- **WAIT_BUSY**
  - When `Tx_BUSY`=1, go to WAIT_DONE.
  - If `Tx_BUSY` stays 0 for TO_CYC cycles, set `err_timeout` and go to IDLE.
- **WAIT_DONE**: when `Tx_BUSY`=0, go to IDLE.
- `Tx_DATA` holds the latched byte from the grant until the next grant. Changes to `req_data` or `req` after the grant have no effect on the in-flight byte.
- `en` falling mid-transfer does not abort the transfer. The current frame completes, and no new grant is made until `en`=1.
- **Baud configuration**
  - `cfg_wr` in IDLE with no grant that edge: `baud_select` takes `cfg_baud` on that edge.
  - `cfg_wr` at any other time: the value is held pending and applied on the first IDLE edge, before any new grant. The next grant occurs one cycle later.
  - If several `cfg_wr` strobes arrive while pending, the last value wins.
- **Reset values**: state IDLE, `rr_ptr`=0, `Tx_DATA`=0, `Tx_WR`=0, `ack`=0, `Tx_EN`=0, `baud_select`=3'b111, `grant_id`=0, `busy`=0, `err_timeout`=0, no pending config.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Request latency: `req` sampled high at edge k (in IDLE) gives `Tx_WR`/`ack` high for the cycle after edge k. Both drop after edge k+1.
- Minimum spacing between successive `Tx_WR` pulses is 4 cycles (WRITE, WAIT_BUSY ≥1, WAIT_DONE ≥1, IDLE).
- Timeout: WAIT_BUSY is entered at edge k+1. `err_timeout` rises at edge k+1+TO_CYC if `Tx_BUSY` was never sampled high.
- A requester granted last has the lowest priority in the next arbitration. Under continuous requests from all, the grant order is 0,1,…,N_REQ−1,0.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously. Any pending config is discarded. The transmitter's own reset handles the line.

## Test plan
- Single request: `req`=0001, `req_data[7:0]`=8'h99, `en`=1 → exactly one `Tx_WR` pulse with `Tx_DATA`=8'h99 and `ack`=0001 in the same cycle. `busy` stays high until `Tx_BUSY` falls.
- Simultaneous requests: `req`=1111, held and re-asserted after each ack, bytes A0..A3 → grant order 0,1,2,3,0 and `Tx_DATA` sequence A0,A1,A2,A3,A0.
- Pointer wrap: grant 2, then `req`=0101 → next grant is 0 (search 3→0). The same case with `req`=1101 → next grant is 3.
- Timeout: `Tx_BUSY` tied low, TO_CYC=15 → `err_timeout`=1 exactly 15 cycles after WAIT_BUSY entry, state returns to IDLE. A subsequent `cfg_wr` clears the flag.
- Deferred baud: `cfg_wr` with 3'b010 during WAIT_DONE while `req`=0010 is pending → `baud_select` updates to 010 on the IDLE edge. `Tx_WR` for requester 1 follows one cycle later, never before.
- Reset mid-frame and enable gating: pull `reset` low during WAIT_DONE → `busy`=0, `Tx_WR`=0, `baud_select`=111 immediately. After release with `en`=0 and `req`=1111 → no `Tx_WR` for 50 cycles; setting `en`=1 → first grant to requester 0.
